// File: rtl/rep3_serial_tx.sv
// Serial transmitter for a repetition-coded line: each framed bit is sent REP times so the far end can majority-vote.
// Optional even-parity bit between data and stop is built when REP3_TX_PARITY_EN is defined.
module rep3_serial_tx #(
    parameter int DATA_W       = 8,
    parameter int REP          = 3,
    parameter int CLKS_PER_SYM = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] D,
    input  logic              VALID,
    output logic              READY,
    output logic              TX,
    output logic              BUSY,
    output logic              DONE
);

    localparam int CW = (CLKS_PER_SYM > 1) ? $clog2(CLKS_PER_SYM) : 1;
    localparam int RW = (REP > 1) ? $clog2(REP) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_SYM - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REP - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef REP3_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t            state;
    logic [CW-1:0]     clk_cnt;
    logic [CW-1:0]     clk_cnt_nxt;
    logic [RW-1:0]     rep_cnt;
    logic [RW-1:0]     rep_cnt_nxt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_nxt;
    logic              sym_end;
    logic              last_cycle_nxt;
`ifdef REP3_TX_PARITY_EN
    logic              parity;
`endif

    // Symbol timing: clk_cnt rolls into rep_cnt; sym_end marks the final cycle of a bit's last copy.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
        clk_cnt_nxt = (clk_cnt == CLK_LAST) ? '0 : clk_cnt + CW'(1);
        rep_cnt_nxt = rep_cnt;
        if (clk_cnt == CLK_LAST) begin
            rep_cnt_nxt = (rep_cnt == REP_LAST) ? '0 : rep_cnt + RW'(1);
        end
        sym_end        = (clk_cnt == CLK_LAST) && (rep_cnt == REP_LAST);
        last_cycle_nxt = (clk_cnt_nxt == CLK_LAST) && (rep_cnt_nxt == REP_LAST);
        shift_nxt      = shift >> 1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: the shift register is ordinary flops, not a memory, so it is cleared with the rest.
            state   <= S_IDLE;
            clk_cnt <= '0;
            rep_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            TX      <= 1'b1;
            READY   <= 1'b1;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
`ifdef REP3_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            if (state != S_IDLE) begin
                clk_cnt <= clk_cnt_nxt;
                rep_cnt <= rep_cnt_nxt;
            end

            case (state)
                S_IDLE: begin
                    if (VALID && READY) begin
                        shift <= D;
`ifdef REP3_TX_PARITY_EN
                        parity <= ^D;
`endif
                        state <= S_START;
                        TX    <= 1'b0;
                        READY <= 1'b0;
                        BUSY  <= 1'b1;
                    end
                end

                S_START: begin
                    if (sym_end) begin
                        state <= S_DATA;
                        TX    <= shift[0];
                    end
                end

                S_DATA: begin
                    if (sym_end) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef REP3_TX_PARITY_EN
                            state   <= S_PARITY;
                            TX      <= parity;
`else
                            state   <= S_STOP;
                            TX      <= 1'b1;
                            DONE    <= last_cycle_nxt;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            shift   <= shift_nxt;
                            TX      <= shift_nxt[0];
                        end
                    end
                end

`ifdef REP3_TX_PARITY_EN
                S_PARITY: begin
                    if (sym_end) begin
                        state <= S_STOP;
                        TX    <= 1'b1;
                        DONE  <= last_cycle_nxt;
                    end
                end
`endif

                // DONE is raised one edge early so it is high exactly during the final stop cycle.
                S_STOP: begin
                    if (sym_end) begin
                        state <= S_IDLE;
                        READY <= 1'b1;
                        BUSY  <= 1'b0;
                    end else begin
                        DONE <= last_cycle_nxt;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rep3_serial_tx.sv
// Self-checking bench for rep3_serial_tx: table-driven and random frames against a waveform model,
// majority-vote loopback, back-to-back, mid-frame reset and the 1/1/1 corner configuration.
module tb_rep3_serial_tx;

    localparam int DATA_W = 8;
    localparam int REP    = 3;
    localparam int CPS    = 4;
`ifdef REP3_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int SYM   = REP * CPS;
    localparam int NBITS = DATA_W + 2 + PAR_BITS;
    localparam int F     = NBITS * SYM;
    localparam int F1    = 3 + PAR_BITS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] d = '0;
    logic              valid = 1'b0;
    logic              ready, tx, busy, done;
    logic [0:0]        d1 = '0;
    logic              valid1 = 1'b0;
    logic              ready1, tx1, busy1, done1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rep3_serial_tx #(.DATA_W(DATA_W), .REP(REP), .CLKS_PER_SYM(CPS)) dut (
        .CLK(clk), .RST_N(rst_n), .D(d), .VALID(valid),
        .READY(ready), .TX(tx), .BUSY(busy), .DONE(done)
    );

    rep3_serial_tx #(.DATA_W(1), .REP(1), .CLKS_PER_SYM(1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .D(d1), .VALID(valid1),
        .READY(ready1), .TX(tx1), .BUSY(busy1), .DONE(done1)
    );

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              par;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic parity_of(input logic [DATA_W-1:0] w);
        int ones = 0;
        for (int i = 0; i < DATA_W; i++) if (w[i]) ones++;
        return logic'(ones % 2);
    endfunction

    // Line level c cycles after the handshake edge, from the frame layout.
    function automatic logic exp_tx(input logic [DATA_W-1:0] w, input logic par, input int c);
        int sym = c / SYM;
        if (sym == 0) return 1'b0;
        if (sym <= DATA_W) return w[sym-1];
        if (PAR_BITS == 1 && sym == DATA_W + 1) return par;
        return 1'b1;
    endfunction

    // Waits (bounded) for READY, presents the word, and returns right after the handshake edge.
    task automatic handshake(input logic [DATA_W-1:0] w);
        int waited = 0;
        while (ready !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (ready !== 1'b1) check("ready_timeout", ready, 1);
        d     = w;
        valid = 1'b1;
        @(posedge clk);
    endtask

    task automatic run_frame(input logic [DATA_W-1:0] w, input logic par, input logic hold,
                             input logic [DATA_W-1:0] nd, input string tag);
        logic              samp [NBITS*REP];
        logic [DATA_W-1:0] dec;
        int bad_tx = 0, first_bad = -1, bad_hs = 0, done_cnt = 0, done_at = -1;
        for (int c = 0; c < F; c++) begin
            @(negedge clk);
            if (tx !== exp_tx(w, par, c)) begin
                bad_tx++;
                if (first_bad < 0) first_bad = c;
            end
            if (ready !== 1'b0 || busy !== 1'b1) bad_hs++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            if (c % CPS == CPS / 2) samp[c/CPS] = tx;
            if (c == 0) begin
                valid = hold;
                d     = nd;
            end
        end
        check($sformatf("%s tx_bad_cycles(first=%0d)", tag, first_bad), bad_tx, 0);
        check($sformatf("%s ready_busy_bad_cycles", tag), bad_hs, 0);
        check($sformatf("%s done_pulses", tag), done_cnt, 1);
        check($sformatf("%s done_cycle", tag), done_at, F - 1);

        // Loopback: corrupt one copy of every three, then majority-vote each data bit.
        for (int j = 0; j < DATA_W; j++) begin
            int ones = 0;
            for (int r = 0; r < REP; r++) begin
                logic v = samp[(j+1)*REP + r];
                if (r == j % REP) v = ~v;
                if (v) ones++;
            end
            dec[j] = (ones > REP / 2);
        end
        check($sformatf("%s voted_word", tag), dec, w);

        @(negedge clk);
        check($sformatf("%s idle_tx_ready_busy_done", tag), {tx, ready, busy, done}, 4'b1100);
    endtask

    task automatic corner(input logic bitv);
        int bad = 0;
        check("corner ready_before", ready1, 1);
        d1     = bitv;
        valid1 = 1'b1;
        @(posedge clk);
        for (int c = 0; c < F1; c++) begin
            logic etx;
            @(negedge clk);
            if (c == 0)                       etx = 1'b0;
            else if (c == 1)                  etx = bitv;
            else if (PAR_BITS == 1 && c == 2) etx = bitv;
            else                              etx = 1'b1;
            if (tx1 !== etx || done1 !== (c == F1 - 1) || busy1 !== 1'b1) bad++;
            if (c == 0) valid1 = 1'b0;
        end
        check($sformatf("corner d=%0b bad_cycles", bitv), bad, 0);
        @(negedge clk);
        check($sformatf("corner d=%0b idle", bitv), {tx1, ready1, busy1, done1}, 4'b1100);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [8];
        tbl[0] = '{8'hA5, 1'b0};
        tbl[1] = '{8'h07, 1'b1};
        tbl[2] = '{8'h03, 1'b0};
        tbl[3] = '{8'h5A, 1'b0};
        tbl[4] = '{8'hC3, 1'b0};
        tbl[5] = '{8'h01, 1'b1};
        tbl[6] = '{8'h80, 1'b1};
        tbl[7] = '{8'h3C, 1'b0};

        // Reset values
        #12;
        check("reset tx_ready_busy_done", {tx, ready, busy, done}, 4'b1100);
        check("reset corner_outputs", {tx1, ready1, busy1, done1}, 4'b1100);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Mid-frame reset during DATA of 0xA5
        begin
            int bad = 0;
            handshake(8'hA5);
            @(negedge clk);
            valid = 1'b0;
            repeat (29) @(negedge clk);
            check("midframe busy_before_reset", busy, 1);
            #2 rst_n = 1'b0;
            #1 check("midframe async_reset", {tx, ready, busy, done}, 4'b1100);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (2 * SYM) begin
                @(negedge clk);
                if ({tx, ready, busy, done} !== 4'b1100) bad++;
            end
            check("after_reset stays_idle_no_done", bad, 0);
        end
        handshake(8'hA5);
        run_frame(8'hA5, 1'b0, 1'b0, 8'h00, "post_reset A5");

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            handshake(tbl[i].d);
            run_frame(tbl[i].d, tbl[i].par, 1'b0, '0, $sformatf("tbl[%0d] %02h", i, tbl[i].d));
        end

        // Back-to-back with VALID held and D changing mid-frame
        handshake(8'h00);
        run_frame(8'h00, 1'b0, 1'b1, 8'hFF, "b2b first 00");
        @(posedge clk);
        run_frame(8'hFF, 1'b0, 1'b0, 8'h00, "b2b second FF");

        // Randomized words against the model
        for (int i = 0; i < 4; i++) begin
            logic [DATA_W-1:0] w = DATA_W'($urandom);
            handshake(w);
            run_frame(w, parity_of(w), 1'b0, DATA_W'($urandom), $sformatf("rand[%0d] %02h", i, w));
        end

        // Degenerate 1-bit, 1-copy, 1-clock configuration
        corner(1'b1);
        corner(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rep3_serial_tx.md
# rep3_serial_tx

Serial transmitter for a triple-repetition-coded line: accepts a parallel word through a valid/ready handshake and sends each framed bit REP times in succession, so the receiving end can recover every bit with a 3-input majority vote (M = AB + BC + CA) over the copies. It sits on the transmit side of the link, opposite the majority-vote decoder, and drives the single-wire TX line directly.

## Interface
- DATA_W, 8, payload bits per frame (≥1)
- REP, 3, copies per bit; odd, ≥1 (3 matches the 3-input voter)
- CLKS_PER_SYM, 4, clock cycles each copy is held on TX (≥1)

- CLK  input  1  single clock, rising edge active
- RST_N  input  1  asynchronous, active-low reset
- D  input  DATA_W  payload; sampled only on handshake
- VALID  input  1  D is valid; held until accepted
- READY  output  1  block can accept a word
- TX  output  1  serial line; idles high
- BUSY  output  1  frame in progress
- DONE  output  1  one-cycle pulse at end of frame

## Operation
- One clock; reset is asynchronous and active-low.
- Frame, in order: start bit (0), DATA_W data bits LSB first, optional parity bit, stop bit (1). Each bit is sent as REP identical copies, each copy held CLKS_PER_SYM cycles.
- States:
  - IDLE: TX=1, READY=1, BUSY=0. On VALID&&READY at a clock edge, latch D into the shift register and go to START.
  - START: TX=0 for REP×CLKS_PER_SYM cycles, then DATA.
  - DATA: TX=shift[0]. Shift right after each REP×CLKS_PER_SYM cycles. Go to PARITY (if compiled) or STOP after DATA_W bits.
  - PARITY: TX=even parity of the latched word, held REP×CLKS_PER_SYM cycles.
  - STOP: TX=1 for REP×CLKS_PER_SYM cycles. On the last cycle, DONE=1 and the next state is IDLE.
- Counters: clk_cnt 0..CLKS_PER_SYM−1, rep_cnt 0..REP−1, bit_cnt 0..DATA_W−1. Each counter wraps to 0 and advances the next counter when it reaches its terminal count. All counters are 0 in IDLE.
- While BUSY, VALID and changes on D are ignored; the latched word is the only source for the frame.
- TX, READY, BUSY and DONE are registered outputs; there is no combinational input-to-output path.
- Reset values: TX=1, READY=1, BUSY=0, DONE=0, state IDLE, all counters and the shift register 0.
- If reset is asserted mid-frame, the frame aborts and TX goes to 1 immediately (asynchronous). No DONE is issued. After release, the block is in IDLE.

## Timing
- Handshake edge = edge n. TX falls, READY falls and BUSY rises in the cycle that starts at edge n.
- Frame length F = (DATA_W+2[+1 with parity])×REP×CLKS_PER_SYM cycles. With defaults F=120, or 132 with parity.
- DONE is high during the last of the F cycles. At the following edge, READY=1 and BUSY=0.
- Back-to-back: if VALID is held high, the next word is accepted at the first edge where READY=1. TX then has exactly one idle-high cycle between frames, so the maximum throughput is one word per F+1 cycles.
- Data bit k (0-based) occupies cycles [(1+k)×REP×CLKS_PER_SYM, (2+k)×REP×CLKS_PER_SYM) after the handshake edge.
- With CLKS_PER_SYM=1 and REP=1, the block degenerates to a plain 1-clock-per-bit UART-style framer and must behave correctly.

## Configuration
- REP3_TX_PARITY_EN defined: the PARITY state is present, an even-parity bit (XOR of all DATA_W bits) is sent REP times between data and stop, and F includes it.
- Not defined: the PARITY state and parity logic are not built; STOP follows the last data bit directly.

## Test plan
- Reset: assert RST_N=0 mid-DATA of frame 0xA5 → TX=1, READY=1, BUSY=0, DONE=0 at once. After release, no DONE pulse and the next handshake starts a clean frame.
- Single frame, defaults, D=0xA5 → TX shows 12 cycles low, then 1,0,1,0,0,1,0,1 with each bit held 12 cycles, then 12 cycles high. DONE pulses at cycle 119 after the handshake edge.
- Back-to-back 0x00 then 0xFF with VALID held → second start bit begins exactly one idle cycle after the first frame's DONE. The D change during frame 1 does not alter its bits.
- Parity build, D=0x07 → parity copies are 1 (12 cycles), F=132. D=0x03 → parity is 0.
- Loopback into the majority voter: sample TX at the middle of each copy and flip one of every three copies → the decoded word equals D for 0x5A and 0xC3.
- Corner case DATA_W=1, REP=1, CLKS_PER_SYM=1, D=1 → TX sequence 0,1,1 then idle. DONE is on the third cycle.
